// File: rtl/mem_stage_pkg.sv
// Shared types, widths and helpers for the memory-access stage.
package mem_stage_pkg;

    localparam int XLEN      = 32;
    localparam int REG_SEL_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that must be able to hold the value TIMEOUT.
    function automatic int TO_W(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: word loads/stores over a req/ack port, pipeline freeze
// while an access is outstanding, and the registered writeback bundle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int                TIMEOUT  = 255,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 icache_stall,
    input  logic [XLEN-1:0]      ac_pc,
    input  logic [REG_SEL_W-1:0] ac_write_sel,
    input  logic                 ac_is_load,
    input  logic                 ac_is_store,
    input  logic                 ac_is_wb,
    input  logic [XLEN-1:0]      ALU_result,
    input  logic [XLEN-1:0]      ac_data2,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 dcache_stall,
    output logic                 mem_fault,
    output logic [XLEN-1:0]      cw_pc,
    output logic [REG_SEL_W-1:0] cw_write_sel,
    output logic                 cw_is_wb,
    output logic [XLEN-1:0]      cw_result
);

    localparam int               CNT_W    = TO_W(TIMEOUT);
    // Last count value at which an un-acked REQ cycle triggers the abort.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   abort_q, abort_d;
    logic [XLEN-1:0]        load_buf_q, load_buf_d;
    logic                   dmem_req_q, dmem_req_d;
    logic                   dmem_we_q, dmem_we_d;
    logic [XLEN-1:0]        dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]        dmem_wdata_q, dmem_wdata_d;
    logic                   mem_fault_q, mem_fault_d;
    logic [XLEN-1:0]        cw_pc_q, cw_pc_d;
    logic [REG_SEL_W-1:0]   cw_write_sel_q, cw_write_sel_d;
    logic                   cw_is_wb_q, cw_is_wb_d;
    logic [XLEN-1:0]        cw_result_q, cw_result_d;

    logic                   mem_op_s;
    logic                   misaligned_s;
    logic                   start_s;
    logic                   timeout_s;
    logic                   dcache_stall_s;
    logic                   update_s;

    // Decode the current instruction and derive stall / retire conditions.
    always_comb begin
        mem_op_s       = ac_is_load | ac_is_store;
        misaligned_s   = mem_op_s & (ALU_result[1:0] != 2'b00);
        start_s        = 1'b0;
        timeout_s      = 1'b0;
        dcache_stall_s = 1'b0;
        case (state_q)
            IDLE: begin
                start_s        = mem_op_s & ~misaligned_s & ~icache_stall;
                dcache_stall_s = start_s;
            end
            REQ: begin
                timeout_s      = ~dmem_ack & (cnt_q == CNT_LAST);
                dcache_stall_s = 1'b1;
            end
            DONE: begin
                dcache_stall_s = 1'b0;
            end
            default: begin
                dcache_stall_s = 1'b0;
            end
        endcase
        update_s = ~dcache_stall_s & ~icache_stall;
    end

    // Access FSM next state, request registers, timeout counter and fault pulse.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        abort_d      = abort_q;
        load_buf_d   = load_buf_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        mem_fault_d  = timeout_s | (update_s & misaligned_s);
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                if (start_s) begin
                    state_d      = REQ;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = ac_is_store;
                    dmem_addr_d  = {ALU_result[XLEN-1:2], 2'b00};
                    dmem_wdata_d = ac_data2;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dmem_ack) begin
                    load_buf_d = dmem_rdata;
                    dmem_req_d = 1'b0;
                    state_d    = DONE;
                end else if (timeout_s) begin
                    dmem_req_d = 1'b0;
                    abort_d    = 1'b1;
                    state_d    = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            DONE: begin
                cnt_d = '0;
                if (!icache_stall) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d    = IDLE;
                dmem_req_d = 1'b0;
                cnt_d      = '0;
            end
        endcase
    end

    // Writeback bundle: capture the retiring instruction, otherwise hold.
    always_comb begin
        cw_pc_d        = cw_pc_q;
        cw_write_sel_d = cw_write_sel_q;
        cw_is_wb_d     = cw_is_wb_q;
        cw_result_d    = cw_result_q;
        if (update_s) begin
            cw_pc_d        = ac_pc;
            cw_write_sel_d = ac_write_sel;
            cw_is_wb_d     = ac_is_wb & ~misaligned_s & ~abort_q;
            cw_result_d    = ac_is_load ? load_buf_q : ALU_result;
        end else begin
            cw_pc_d = cw_pc_q;
        end
    end

    // State, request and writeback registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            abort_q        <= 1'b0;
            load_buf_q     <= '0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            mem_fault_q    <= 1'b0;
            cw_pc_q        <= RESET_PC;
            cw_write_sel_q <= '0;
            cw_is_wb_q     <= 1'b0;
            cw_result_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            abort_q        <= abort_d;
            load_buf_q     <= load_buf_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            mem_fault_q    <= mem_fault_d;
            cw_pc_q        <= cw_pc_d;
            cw_write_sel_q <= cw_write_sel_d;
            cw_is_wb_q     <= cw_is_wb_d;
            cw_result_q    <= cw_result_d;
        end
    end

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign dcache_stall = dcache_stall_s;
    assign mem_fault    = mem_fault_q;
    assign cw_pc        = cw_pc_q;
    assign cw_write_sel = cw_write_sel_q;
    assign cw_is_wb     = cw_is_wb_q;
    assign cw_result    = cw_result_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TIMEOUT = 4).
module tb_mem_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clock;
    logic        reset;
    logic        icache_stall;
    logic [31:0] ac_pc;
    logic [4:0]  ac_write_sel;
    logic        ac_is_load;
    logic        ac_is_store;
    logic        ac_is_wb;
    logic [31:0] ALU_result;
    logic [31:0] ac_data2;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dcache_stall;
    logic        mem_fault;
    logic [31:0] cw_pc;
    logic [4:0]  cw_write_sel;
    logic        cw_is_wb;
    logic [31:0] cw_result;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.TIMEOUT(4), .RESET_PC(RST_PC)) dut (
        .clock        (clock),
        .reset        (reset),
        .icache_stall (icache_stall),
        .ac_pc        (ac_pc),
        .ac_write_sel (ac_write_sel),
        .ac_is_load   (ac_is_load),
        .ac_is_store  (ac_is_store),
        .ac_is_wb     (ac_is_wb),
        .ALU_result   (ALU_result),
        .ac_data2     (ac_data2),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .dcache_stall (dcache_stall),
        .mem_fault    (mem_fault),
        .cw_pc        (cw_pc),
        .cw_write_sel (cw_write_sel),
        .cw_is_wb     (cw_is_wb),
        .cw_result    (cw_result)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_inputs();
        icache_stall = 1'b0;
        ac_pc        = 32'h0;
        ac_write_sel = 5'd0;
        ac_is_load   = 1'b0;
        ac_is_store  = 1'b0;
        ac_is_wb     = 1'b0;
        ALU_result   = 32'h0;
        ac_data2     = 32'h0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'h0;
    endtask

    // Run one memory instruction (inputs already applied) until it retires.
    // ack_on: REQ cycle number that sees dmem_ack (0 = never).
    // hold_done: cycles icache_stall is held high in DONE.
    task automatic run_mem(input int ack_on, input int hold_done,
                           output int stalls, output int req_cycles,
                           output int req_rises, output int faults,
                           output logic cap_we, output logic [31:0] cap_addr,
                           output logic [31:0] cap_wdata);
        logic prev_req;
        stalls = 0; req_cycles = 0; req_rises = 0; faults = 0;
        cap_we = 1'b0; cap_addr = 32'h0; cap_wdata = 32'h0;
        prev_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (dmem_req) begin
                req_cycles++;
                if (!prev_req) begin
                    req_rises++;
                    cap_we    = dmem_we;
                    cap_addr  = dmem_addr;
                    cap_wdata = dmem_wdata;
                end
            end
            prev_req = dmem_req;
            dmem_ack = (ack_on != 0) && (req_cycles == ack_on);
            #1;
            if (mem_fault) faults++;
            if (!dcache_stall) break;
            stalls++;
            step();
        end
        dmem_ack = 1'b0;
        if (hold_done > 0) begin
            icache_stall = 1'b1;
            for (int h = 0; h < hold_done; h++) begin
                step();
                if (dmem_req) req_rises++;
                if (mem_fault) faults++;
                check("done_hold_no_stall", 32'(dcache_stall), 32'd0);
            end
            icache_stall = 1'b0;
        end
        step();
        clr_inputs();
        if (mem_fault) faults++;
    endtask

    int          st, rc, rr, fl;
    logic        we_c;
    logic [31:0] addr_c, wdata_c;

    initial begin
        clr_inputs();
        // Reset held for 3 cycles with ack asserted.
        reset    = 1'b0;
        dmem_ack = 1'b1;
        repeat (3) step();
        check("rst_req",      32'(dmem_req),     32'd0);
        check("rst_we",       32'(dmem_we),      32'd0);
        check("rst_addr",     dmem_addr,         32'd0);
        check("rst_wdata",    dmem_wdata,        32'd0);
        check("rst_stall",    32'(dcache_stall), 32'd0);
        check("rst_fault",    32'(mem_fault),    32'd0);
        check("rst_cw_pc",    cw_pc,             RST_PC);
        check("rst_cw_sel",   32'(cw_write_sel), 32'd0);
        check("rst_cw_wb",    32'(cw_is_wb),     32'd0);
        check("rst_cw_res",   cw_result,         32'd0);
        dmem_ack = 1'b0;
        reset    = 1'b1;
        step();

        // ALU passthrough: retires on the next edge with no stall.
        ac_pc = 32'h40; ac_is_wb = 1'b1; ac_write_sel = 5'd5; ALU_result = 32'h1234;
        #1;
        check("alu_stall", 32'(dcache_stall), 32'd0);
        step();
        clr_inputs();
        check("alu_sel",  32'(cw_write_sel), 32'd5);
        check("alu_res",  cw_result,         32'h1234);
        check("alu_wb",   32'(cw_is_wb),     32'd1);
        check("alu_pc",   cw_pc,             32'h40);

        // Load acked in the 4th REQ cycle: 5 stall cycles.
        ac_pc = 32'h44; ac_is_load = 1'b1; ac_is_wb = 1'b1; ac_write_sel = 5'd7;
        ALU_result = 32'h100; dmem_rdata = 32'hDEADBEEF;
        run_mem(4, 0, st, rc, rr, fl, we_c, addr_c, wdata_c);
        check("ld_addr",   addr_c,            32'h100);
        check("ld_we",     32'(we_c),         32'd0);
        check("ld_stalls", 32'(st),           32'd5);
        check("ld_reqcyc", 32'(rc),           32'd4);
        check("ld_res",    cw_result,         32'hDEADBEEF);
        check("ld_wb",     32'(cw_is_wb),     32'd1);
        check("ld_sel",    32'(cw_write_sel), 32'd7);
        check("ld_pc",     cw_pc,             32'h44);
        check("ld_fault",  32'(fl),           32'd0);

        // Store acked immediately, icache_stall held 2 cycles in DONE.
        ac_pc = 32'h50; ac_is_store = 1'b1; ac_write_sel = 5'd3;
        ALU_result = 32'h20; ac_data2 = 32'hA5A5A5A5;
        run_mem(1, 2, st, rc, rr, fl, we_c, addr_c, wdata_c);
        check("st_rises",  32'(rr),       32'd1);
        check("st_we",     32'(we_c),     32'd1);
        check("st_wdata",  wdata_c,       32'hA5A5A5A5);
        check("st_addr",   addr_c,        32'h20);
        check("st_stalls", 32'(st),       32'd2);
        check("st_pc",     cw_pc,         32'h50);
        check("st_res",    cw_result,     32'h20);
        check("st_wb",     32'(cw_is_wb), 32'd0);

        // Misaligned load: no request, no stall, one-cycle fault.
        ac_pc = 32'h60; ac_is_load = 1'b1; ac_is_wb = 1'b1; ac_write_sel = 5'd9;
        ALU_result = 32'h103;
        #1;
        check("mis_stall", 32'(dcache_stall), 32'd0);
        step();
        clr_inputs();
        check("mis_req",    32'(dmem_req),  32'd0);
        check("mis_fault1", 32'(mem_fault), 32'd1);
        check("mis_wb",     32'(cw_is_wb),  32'd0);
        check("mis_pc",     cw_pc,          32'h60);
        step();
        check("mis_fault2", 32'(mem_fault), 32'd0);

        // Timeout: never acked, aborted after 4 REQ cycles.
        ac_pc = 32'h70; ac_is_load = 1'b1; ac_is_wb = 1'b1; ac_write_sel = 5'd4;
        ALU_result = 32'h200;
        run_mem(0, 0, st, rc, rr, fl, we_c, addr_c, wdata_c);
        check("to_reqcyc", 32'(rc),       32'd4);
        check("to_stalls", 32'(st),       32'd5);
        check("to_faults", 32'(fl),       32'd1);
        check("to_wb",     32'(cw_is_wb), 32'd0);
        check("to_pc",     cw_pc,         32'h70);
        step();
        check("to_req_after", 32'(dmem_req), 32'd0);

        // Reset asserted mid-REQ drops the request immediately.
        ac_pc = 32'h80; ac_is_load = 1'b1; ac_is_wb = 1'b1; ALU_result = 32'h300;
        step();
        check("mr_req_up", 32'(dmem_req), 32'd1);
        step();
        reset = 1'b0;
        #1;
        check("mr_req_drop", 32'(dmem_req), 32'd0);
        check("mr_pc",       cw_pc,         RST_PC);
        clr_inputs();
        step();
        reset = 1'b1;
        step();

        // Recovery, destination x0 passed through unchanged.
        ac_pc = 32'h90; ac_is_wb = 1'b1; ac_write_sel = 5'd0; ALU_result = 32'h55;
        step();
        clr_inputs();
        check("x0_sel", 32'(cw_write_sel), 32'd0);
        check("x0_res", cw_result,         32'h55);
        check("x0_wb",  32'(cw_is_wb),     32'd1);
        check("x0_req", 32'(dmem_req),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
